// File: rtl/bus_sync_pkg.sv
// Shared defaults and event-detection helper for the bus_sync CDC block.
package bus_sync_pkg;

    localparam int DEFAULT_NUM_STAGES = 2;
    localparam int DEFAULT_BUS_WIDTH  = 8;
    localparam int DEFAULT_CNT_WIDTH  = 4;

    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;

    // Level mode fires on a rising edge only; toggle mode fires on any change.
    function automatic logic detect_event(input int mode, input logic cur, input logic prev);
        if (mode == MODE_TOGGLE) begin
            return cur ^ prev;
        end
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/bus_sync_chain.sv
// Plain multi-flop synchroniser, reusable for any single-bit (or gray-coded) CDC signal.
module sync_chain
    import bus_sync_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int WIDTH      = 1
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [NUM_STAGES-1:0][WIDTH-1:0] stage_q;

    // Stage 0 is the metastability-catching flop; nothing sits between stages.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[NUM_STAGES-2:0], async_in};
        end
    end

    assign sync_out = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync.sv
// Qualifier-based bus synchroniser: a synchronised enable event captures a held data bus
// and bumps a wrapping event counter.
module bus_sync
    import bus_sync_pkg::*;
#(
    parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
    parameter int BUS_WIDTH   = DEFAULT_BUS_WIDTH,
    parameter int TOGGLE_MODE = MODE_LEVEL,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
)(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic                 pulse,
    output logic                 enable_pulse,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic [CNT_WIDTH-1:0] event_cnt
);

    logic                 enable_sync;
    logic                 edge_q, edge_d;
    logic                 enable_pulse_q, enable_pulse_d;
    logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
    logic [CNT_WIDTH-1:0] event_cnt_q, event_cnt_d;

    sync_chain #(
        .NUM_STAGES (NUM_STAGES),
        .WIDTH      (1)
    ) u_enable_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (bus_enable),
        .sync_out (enable_sync)
    );

    // Reset clears the chain and edge_q together, so pulse is forced low while RST is high.
    assign pulse = detect_event(TOGGLE_MODE, enable_sync, edge_q);

    always_comb begin
        edge_d         = enable_sync;
        enable_pulse_d = pulse;
        sync_bus_d     = sync_bus_q;
        event_cnt_d    = event_cnt_q;
        if (pulse) begin
            sync_bus_d  = unsync_bus;
            event_cnt_d = event_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_q         <= 1'b0;
            enable_pulse_q <= 1'b0;
            sync_bus_q     <= '0;
            event_cnt_q    <= '0;
        end else begin
            edge_q         <= edge_d;
            enable_pulse_q <= enable_pulse_d;
            sync_bus_q     <= sync_bus_d;
            event_cnt_q    <= event_cnt_d;
        end
    end

    assign enable_pulse = enable_pulse_q;
    assign sync_bus     = sync_bus_q;
    assign event_cnt    = event_cnt_q;

endmodule

// File: tb/tb_bus_sync.sv
// Self-checking bench for bus_sync: a level-mode (N=2) and a toggle-mode (N=3) instance
// checked against directed expectations and a history-based reference model.
module tb_bus_sync;
    import bus_sync_pkg::*;

    localparam int LN = 2;
    localparam int TN = 3;
    localparam int BW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic          pulse;
        logic          enPulse;
        logic [BW-1:0] sync;
        logic [CW-1:0] cnt;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [BW-1:0] busL = '0, busT = '0;
    logic enL = 1'b0, enT = 1'b0;

    logic pulseL, enPulseL, pulseT, enPulseT;
    logic [BW-1:0] syncL, syncT;
    logic [CW-1:0] cntL, cntT;

    int checks = 0;
    int failures = 0;

    model_t mL = '0, mT = '0;
    bit histL[$];
    bit histT[$];

    always #5 clk = ~clk;

    bus_sync #(.NUM_STAGES(LN), .BUS_WIDTH(BW), .TOGGLE_MODE(MODE_LEVEL), .CNT_WIDTH(CW)) dutLevel (
        .CLK(clk), .RST(rst), .unsync_bus(busL), .bus_enable(enL),
        .pulse(pulseL), .enable_pulse(enPulseL), .sync_bus(syncL), .event_cnt(cntL)
    );

    bus_sync #(.NUM_STAGES(TN), .BUS_WIDTH(BW), .TOGGLE_MODE(MODE_TOGGLE), .CNT_WIDTH(CW)) dutToggle (
        .CLK(clk), .RST(rst), .unsync_bus(busT), .bus_enable(enT),
        .pulse(pulseT), .enable_pulse(enPulseT), .sync_bus(syncT), .event_cnt(cntT)
    );

    // Value of bus_enable sampled at a given clock edge since reset; before reset release it reads 0.
    function automatic bit sampleAt(input bit h[$], input int idx);
        return (idx >= 0 && idx < h.size()) ? h[idx] : 1'b0;
    endfunction

    // An event is visible N-1 edges after it was sampled: compare the sample taken N-1 edges ago
    // against the one before it.
    function automatic bit eventDue(input bit h[$], input int n, input bit toggle);
        int s = h.size();
        bit now  = sampleAt(h, s - n);
        bit prev = sampleAt(h, s - n - 1);
        return toggle ? (now != prev) : (now && !prev);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            histL.delete();
            histT.delete();
            mL = '0;
            mT = '0;
        end else begin
            mL.enPulse = mL.pulse;
            if (mL.pulse) begin
                mL.sync = busL;
                mL.cnt  = mL.cnt + 4'd1;
            end
            histL.push_back(enL);
            if (histL.size() > 8) void'(histL.pop_front());
            mL.pulse = eventDue(histL, LN, 1'b0);

            mT.enPulse = mT.pulse;
            if (mT.pulse) begin
                mT.sync = busT;
                mT.cnt  = mT.cnt + 4'd1;
            end
            histT.push_back(enT);
            if (histT.size() > 8) void'(histT.pop_front());
            mT.pulse = eventDue(histT, TN, 1'b1);
        end
    end

    task automatic resetDuts();
        @(negedge clk);
        #1 rst = 1'b1;
        enL = 1'b0; enT = 1'b0; busL = '0; busT = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks += 8;
        if (pulseL !== 1'b0)   begin failures++; $display("[TB] FAIL reset pulseL got %b want 0", pulseL); end
        if (enPulseL !== 1'b0) begin failures++; $display("[TB] FAIL reset enPulseL got %b want 0", enPulseL); end
        if (syncL !== '0)      begin failures++; $display("[TB] FAIL reset syncL got %h want 00", syncL); end
        if (cntL !== '0)       begin failures++; $display("[TB] FAIL reset cntL got %0d want 0", cntL); end
        if (pulseT !== 1'b0)   begin failures++; $display("[TB] FAIL reset pulseT got %b want 0", pulseT); end
        if (enPulseT !== 1'b0) begin failures++; $display("[TB] FAIL reset enPulseT got %b want 0", enPulseT); end
        if (syncT !== '0)      begin failures++; $display("[TB] FAIL reset syncT got %h want 00", syncT); end
        if (cntT !== '0)       begin failures++; $display("[TB] FAIL reset cntT got %0d want 0", cntT); end
        enL = 1'b1; enT = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks += 2;
            if (pulseL !== 1'b0) begin failures++; $display("[TB] FAIL reset_hold pulseL got %b want 0", pulseL); end
            if (pulseT !== 1'b0) begin failures++; $display("[TB] FAIL reset_hold pulseT got %b want 0", pulseT); end
        end
        rst = 1'b0; enL = 1'b0; enT = 1'b0;
    endtask

    task automatic test_level_latency();
        resetDuts();
        busL = 8'hA5;
        enL  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks += 4;
            if (pulseL !== (c == 2))
                begin failures++; $display("[TB] FAIL latency pulse after edge %0d got %b want %b", c, pulseL, c == 2); end
            if (enPulseL !== (c == 3))
                begin failures++; $display("[TB] FAIL latency enable_pulse after edge %0d got %b want %b", c, enPulseL, c == 3); end
            if (syncL !== ((c >= 3) ? 8'hA5 : 8'h00))
                begin failures++; $display("[TB] FAIL latency sync_bus after edge %0d got %h", c, syncL); end
            if (cntL !== ((c >= 3) ? 4'd1 : 4'd0))
                begin failures++; $display("[TB] FAIL latency event_cnt after edge %0d got %0d", c, cntL); end
        end
    endtask

    task automatic test_level_hold();
        int pulses = 0;
        logic [CW-1:0] cntBeforeFall = '0;
        resetDuts();
        enL = 1'b1;
        for (int c = 0; c < 30; c++) begin
            busL = 8'($urandom);
            if (c == 20) begin
                enL = 1'b0;
                cntBeforeFall = cntL;
            end
            @(negedge clk);
            if (pulseL) pulses++;
            checks++;
            if (pulseL !== mL.pulse) begin failures++; $display("[TB] FAIL hold pulse cycle %0d got %b want %b", c, pulseL, mL.pulse); end
        end
        checks += 3;
        if (pulses != 1) begin failures++; $display("[TB] FAIL hold pulse_count got %0d want 1", pulses); end
        if (cntL !== cntBeforeFall) begin failures++; $display("[TB] FAIL hold cnt_after_fall got %0d want %0d", cntL, cntBeforeFall); end
        if (cntL !== 4'd1) begin failures++; $display("[TB] FAIL hold cnt got %0d want 1", cntL); end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        resetDuts();
        for (int g = 0; g < 5; g++) begin
            #1 enL = 1'b1;
            #2 enL = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (pulseL) pulses++;
            end
        end
        checks += 2;
        if (pulses > 0) begin failures++; $display("[TB] FAIL glitch pulse_count got %0d want 0", pulses); end
        if (cntL !== 4'd0) begin failures++; $display("[TB] FAIL glitch cnt got %0d want 0", cntL); end
    endtask

    task automatic test_toggle_burst();
        logic [BW-1:0] captured[$];
        int pulses = 0;
        resetDuts();
        for (int c = 0; c < 9; c++) begin
            if (c < 3) enT = ~enT;
            if (c >= 3 && c < 6) busT = 8'(c - 2);
            @(negedge clk);
            if (pulseT) pulses++;
            if (enPulseT) captured.push_back(syncT);
            checks += 2;
            if (pulseT !== (c >= 2 && c <= 4))
                begin failures++; $display("[TB] FAIL toggle pulse after edge %0d got %b want %b", c, pulseT, c >= 2 && c <= 4); end
            if (cntT !== mT.cnt)
                begin failures++; $display("[TB] FAIL toggle cnt cycle %0d got %0d want %0d", c, cntT, mT.cnt); end
        end
        checks += 4;
        if (pulses != 3) begin failures++; $display("[TB] FAIL toggle pulse_count got %0d want 3", pulses); end
        if (syncT !== 8'h03) begin failures++; $display("[TB] FAIL toggle final_sync got %h want 03", syncT); end
        if (cntT !== 4'd3) begin failures++; $display("[TB] FAIL toggle final_cnt got %0d want 3", cntT); end
        if (captured.size() != 3) begin
            failures++; $display("[TB] FAIL toggle capture_count got %0d want 3", captured.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (captured[i] !== 8'(i + 1))
                    begin failures++; $display("[TB] FAIL toggle capture %0d got %h want %h", i, captured[i], 8'(i + 1)); end
            end
        end
    endtask

    task automatic test_random_level();
        resetDuts();
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 3) == 0) enL = ~enL;
            busL = 8'($urandom);
            @(negedge clk);
            checks += 4;
            if (pulseL !== mL.pulse)     begin failures++; $display("[TB] FAIL rand_level pulse cycle %0d got %b want %b", c, pulseL, mL.pulse); end
            if (enPulseL !== mL.enPulse) begin failures++; $display("[TB] FAIL rand_level enable_pulse cycle %0d got %b want %b", c, enPulseL, mL.enPulse); end
            if (syncL !== mL.sync)       begin failures++; $display("[TB] FAIL rand_level sync cycle %0d got %h want %h", c, syncL, mL.sync); end
            if (cntL !== mL.cnt)         begin failures++; $display("[TB] FAIL rand_level cnt cycle %0d got %0d want %0d", c, cntL, mL.cnt); end
        end
    endtask

    task automatic test_random_toggle();
        resetDuts();
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 2) == 0) enT = ~enT;
            busT = 8'($urandom);
            @(negedge clk);
            checks += 4;
            if (pulseT !== mT.pulse)     begin failures++; $display("[TB] FAIL rand_toggle pulse cycle %0d got %b want %b", c, pulseT, mT.pulse); end
            if (enPulseT !== mT.enPulse) begin failures++; $display("[TB] FAIL rand_toggle enable_pulse cycle %0d got %b want %b", c, enPulseT, mT.enPulse); end
            if (syncT !== mT.sync)       begin failures++; $display("[TB] FAIL rand_toggle sync cycle %0d got %h want %h", c, syncT, mT.sync); end
            if (cntT !== mT.cnt)         begin failures++; $display("[TB] FAIL rand_toggle cnt cycle %0d got %0d want %0d", c, cntT, mT.cnt); end
        end
    endtask

    task automatic test_wrap();
        resetDuts();
        busL = 8'h3C;
        for (int ev = 1; ev <= 17; ev++) begin
            enL = 1'b1;
            repeat (3) @(negedge clk);
            enL = 1'b0;
            repeat (3) @(negedge clk);
            checks++;
            if (cntL !== 4'(ev % 16))
                begin failures++; $display("[TB] FAIL wrap cnt after event %0d got %0d want %0d", ev, cntL, ev % 16); end
        end
    endtask

    task automatic test_reset_midflight();
        int pulses = 0;
        @(negedge clk);
        enL = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks += 8;
        if (pulseL !== 1'b0)   begin failures++; $display("[TB] FAIL midflight pulseL got %b want 0", pulseL); end
        if (enPulseL !== 1'b0) begin failures++; $display("[TB] FAIL midflight enPulseL got %b want 0", enPulseL); end
        if (syncL !== '0)      begin failures++; $display("[TB] FAIL midflight syncL got %h want 00", syncL); end
        if (cntL !== '0)       begin failures++; $display("[TB] FAIL midflight cntL got %0d want 0", cntL); end
        if (pulseT !== 1'b0)   begin failures++; $display("[TB] FAIL midflight pulseT got %b want 0", pulseT); end
        if (enPulseT !== 1'b0) begin failures++; $display("[TB] FAIL midflight enPulseT got %b want 0", enPulseT); end
        if (syncT !== '0)      begin failures++; $display("[TB] FAIL midflight syncT got %h want 00", syncT); end
        if (cntT !== '0)       begin failures++; $display("[TB] FAIL midflight cntT got %0d want 0", cntT); end
        #3 rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (pulseL) pulses++;
            checks++;
            if (pulseL !== (c == LN))
                begin failures++; $display("[TB] FAIL midflight pulse after edge %0d got %b want %b", c, pulseL, c == LN); end
        end
        checks += 2;
        if (pulses != 1) begin failures++; $display("[TB] FAIL midflight pulse_count got %0d want 1", pulses); end
        if (cntL !== 4'd1) begin failures++; $display("[TB] FAIL midflight cnt got %0d want 1", cntL); end
    endtask

    initial begin
        test_reset();
        test_level_latency();
        test_level_hold();
        test_glitch();
        test_toggle_burst();
        test_random_level();
        test_random_toggle();
        test_wrap();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
